// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared types and constants for the pipeline stall/flush sequencer.
//   - ctrl_state_e : controller FSM encoding (visible on the ctrl_state port)
//   - REG_W        : register-specifier width
//   - REG_ZERO     : hard-wired zero register, never a hazard source
//   - reg_hit()    : one writer-vs-source comparison
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        CTRL_BOOT  = 2'd0,
        CTRL_RUN   = 2'd1,
        CTRL_STALL = 2'd2
    } ctrl_state_e;

    function automatic logic reg_hit(input logic             wreg,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] src);
        return wreg && (rd == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundle between the pipeline (ID/EX/MEM/WB stages) and the hazard controller.
//   Pipeline -> controller : id_rs, id_rt, id_use_rs, id_use_rt,
//                            ex_rd/ex_wreg, mem_rd/mem_wreg, wb_rd/wb_wreg,
//                            ctrl_branch
//   Controller -> pipeline : id_wpcir, ex_bubble, if_flush, ctrl_state,
//                            stall_cnt, flush_cnt, stall_err
//   master = pipeline side, slave = controller side.
//   CNT_W must match the controller's CNT_W.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_wreg;
    logic [REG_W-1:0] mem_rd;
    logic             mem_wreg;
    logic [REG_W-1:0] wb_rd;
    logic             wb_wreg;
    logic             ctrl_branch;

    logic             id_wpcir;
    logic             ex_bubble;
    logic             if_flush;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             stall_err;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
               ex_rd, ex_wreg, mem_rd, mem_wreg, wb_rd, wb_wreg, ctrl_branch,
        input  id_wpcir, ex_bubble, if_flush, ctrl_state,
               stall_cnt, flush_cnt, stall_err
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
               ex_rd, ex_wreg, mem_rd, mem_wreg, wb_rd, wb_wreg, ctrl_branch,
        output id_wpcir, ex_bubble, if_flush, ctrl_state,
               stall_cnt, flush_cnt, stall_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_hazard_cmp
//   RAW check for one ID source operand against the in-flight destinations.
//   Ports:
//     use_src  in  source is actually read by the ID instruction
//     src      in  source register specifier
//     ex_*/mem_*/wb_*  in  destination register and write-enable per stage
//     hit      out source depends on an unwritten result
//   WB_HAZARD=1 when the regfile is not write-first, so a WB writer still
//   hides its value from ID in the same cycle.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl_hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter bit WB_HAZARD = 1'b0
) (
    input  logic             use_src,
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wreg,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wreg,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wreg,
    output logic             hit
);

    logic wb_hit;

    assign wb_hit = WB_HAZARD && reg_hit(wb_wreg, wb_rd, src);

    assign hit = use_src && (src != REG_ZERO) &&
                 (reg_hit(ex_wreg, ex_rd, src) ||
                  reg_hit(mem_wreg, mem_rd, src) ||
                  wb_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Stall/flush sequencer for a 5-stage pipeline without forwarding.
//   Ports:
//     clk   in   pipeline clock, all state on the rising edge
//     rst   in   asynchronous active-low reset
//     hz    slave side of pipe_hazard_ctrl_if (sources, destinations, branch
//           in; id_wpcir, ex_bubble, if_flush, ctrl_state, stall_cnt,
//           flush_cnt, stall_err out)
//   Parameters:
//     CNT_W      width of the saturating stall/flush statistics
//     MAX_STALL  longest legal run of consecutive stall cycles
//     WB_HAZARD  1 = WB destination also hazards
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   BOOT  | first cycle after reset, imem read settling; PC held, ID/EX bubbled
//   RUN   | normal issue; previous cycle had no hazard
//   STALL | previous cycle was stalled on a hazard
//
//   id_wpcir/ex_bubble/if_flush are combinational off the current hazard so
//   the pipeline sees them before the same edge they act on.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 3,
    parameter int WB_HAZARD = 0
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    // run_len saturates one past MAX_STALL, enough to see the overrun.
    localparam int RUN_W = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

    ctrl_state_e      state;
    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] run_next;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             stall_err;
    logic             hit_rs;
    logic             hit_rt;
    logic             hazard;
    logic             booting;
    logic             id_wpcir;
    logic             ex_bubble;
    logic             if_flush;

    pipe_hazard_ctrl_hazard_cmp #(.WB_HAZARD(WB_HAZARD != 0)) u_cmp_rs (
        .use_src  (hz.id_use_rs),
        .src      (hz.id_rs),
        .ex_rd    (hz.ex_rd),
        .ex_wreg  (hz.ex_wreg),
        .mem_rd   (hz.mem_rd),
        .mem_wreg (hz.mem_wreg),
        .wb_rd    (hz.wb_rd),
        .wb_wreg  (hz.wb_wreg),
        .hit      (hit_rs)
    );

    pipe_hazard_ctrl_hazard_cmp #(.WB_HAZARD(WB_HAZARD != 0)) u_cmp_rt (
        .use_src  (hz.id_use_rt),
        .src      (hz.id_rt),
        .ex_rd    (hz.ex_rd),
        .ex_wreg  (hz.ex_wreg),
        .mem_rd   (hz.mem_rd),
        .mem_wreg (hz.mem_wreg),
        .wb_rd    (hz.wb_rd),
        .wb_wreg  (hz.wb_wreg),
        .hit      (hit_rt)
    );

    assign hazard   = hit_rs || hit_rt;
    assign booting  = (state == CTRL_BOOT);
    assign run_next = (run_len == RUN_MAX) ? RUN_MAX : run_len + 1'b1;

    // A branch resolved while stalling used stale operands, so hazard wins.
    always_comb begin
        id_wpcir  = 1'b1;
        ex_bubble = 1'b1;
        if_flush  = 1'b0;
        if (!booting) begin
            id_wpcir  = hazard;
            ex_bubble = hazard;
            if_flush  = hz.ctrl_branch && !hazard;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CTRL_BOOT;
            run_len   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            if (booting) begin
                state   <= CTRL_RUN;
                run_len <= '0;
            end else begin
                state <= hazard ? CTRL_STALL : CTRL_RUN;
                if (hazard) begin
                    run_len <= run_next;
                    if (run_next > RUN_LIMIT)
                        stall_err <= 1'b1;
                    if (stall_cnt != '1)
                        stall_cnt <= stall_cnt + 1'b1;
                end else begin
                    run_len <= '0;
                end
                if (if_flush && (flush_cnt != '1))
                    flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign hz.id_wpcir   = id_wpcir;
    assign hz.ex_bubble  = ex_bubble;
    assign hz.if_flush   = if_flush;
    assign hz.ctrl_state = state;
    assign hz.stall_cnt  = stall_cnt;
    assign hz.flush_cnt  = flush_cnt;
    assign hz.stall_err  = stall_err;

endmodule
